sgpio_rx_multi: RTL and testbench

- Parametrised SGPIO (SFF-8485) target receiver for backplane CPLDs.
- Takes host SCLK/SLOAD/SDATAOUT and deserialises 3 bits per drive for DRIVE_NUM drives.
- Decodes each drive's bits to activity/locate/fault/rebuild LED controls and commits them atomically at end of frame.
- Adds a frame-error flag, vendor L-bit capture, a link-up indicator and a bus-idle watchdog that forces LEDs to a safe value.

---
 rtl/sgpio_pkg.sv | 35 +++
 rtl/sgpio_rx_multi_if.sv | 18 +
 rtl/sgpio_edge_sync.sv | 41 ++++
 rtl/sgpio_rx_multi.sv | 208 ++++++++++++++++++++
 tb/tb_sgpio_rx_multi.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sgpio_pkg.sv
// sgpio_pkg: shared constants, FSM state encoding and the per-drive LED
// decode used by the SGPIO target receiver (sgpio_rx_multi).
// No ports. Imported by the sgpio_rx_multi RTL files.
package sgpio_pkg;

    localparam int BITS_PER_DRIVE = 3;
    localparam int VENDOR_BITS    = 4;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } sgpio_state_e;

    typedef struct packed {
        logic active;
        logic locate;
        logic fault;
        logic rebuild;
    } sgpio_led_t;

    // b = {ODn.2 (fault), ODn.1 (locate), ODn.0 (activity)}.
    // Activity is independent; the {fault,locate} pair selects one of
    // fault / locate / rebuild, or none.
    function automatic sgpio_led_t sgpio_decode(input logic [2:0] b);
        sgpio_led_t r;
        r.active  = b[0];
        r.fault   = (b[2:1] == 2'b10);
        r.locate  = (b[2:1] == 2'b01);
        r.rebuild = (b[2:1] == 2'b11);
        return r;
    endfunction

endpackage

// File: rtl/sgpio_rx_multi_if.sv
// sgpio_rx_multi_if: the SGPIO wire bundle between host and target.
//   sclk, sload, sdout : host -> target
//   sdin               : target -> host (only with SGPIO_SDATAIN_EN)
// Modports: master = host side, slave = target (receiver) side.
// Optional feature macro: SGPIO_SDATAIN_EN.
interface sgpio_rx_multi_if;
    logic sclk;
    logic sload;
    logic sdout;
`ifdef SGPIO_SDATAIN_EN
    logic sdin;
    modport master (output sclk, output sload, output sdout, input sdin);
    modport slave  (input sclk, input sload, input sdout, output sdin);
`else
    modport master (output sclk, output sload, output sdout);
    modport slave  (input sclk, input sload, input sdout);
`endif
endinterface

// File: rtl/sgpio_edge_sync.sv
// sgpio_edge_sync: 2-flop synchroniser for an asynchronous clock line plus
// a third flop that turns it into one-clk rise/fall pulses. The W data
// lines get the same 2-flop depth so they stay aligned with the clock line.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   clk_in            asynchronous clock line to synchronise
//   data_in[W]        asynchronous data lines to synchronise
//   clk_rise/clk_fall one-clk pulses on synchronised edges of clk_in
//   data_q[W]         synchronised data lines
module sgpio_edge_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_in,
    input  logic [W-1:0] data_in,
    output logic         clk_rise,
    output logic         clk_fall,
    output logic [W-1:0] data_q
);

    logic [2:0]   clk_sh;
    logic [W-1:0] data_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sh    <= '0;
            data_meta <= '0;
            data_q    <= '0;
        end else begin
            clk_sh    <= {clk_sh[1:0], clk_in};
            data_meta <= data_in;
            data_q    <= data_meta;
        end
    end

    // clk_sh[1] is the synchronised level, clk_sh[2] its previous value.
    assign clk_rise = clk_sh[1] & ~clk_sh[2];
    assign clk_fall = ~clk_sh[1] & clk_sh[2];

endmodule

// File: rtl/sgpio_rx_multi.sv
// sgpio_rx_multi: SGPIO (SFF-8485) target receiver. Deserialises 3 bits
// per drive for DRIVE_NUM drives, decodes them into LED controls and
// commits them atomically one clk after the last bit of a frame.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   bus (slave)         sclk/sload/sdout from host (+ sdin when enabled)
//   drive_present       per-drive presence (only with SGPIO_SDATAIN_EN)
//   drive_active/locate/fault/rebuild  per-drive LED outputs
//   vendor_bits         L0..L3 of the last committed frame (L0 in bit 0)
//   frame_done          one-clk pulse on commit
//   frame_err           one-clk pulse when a frame is restarted short
//   link_up             high from first commit until timeout/reset
//   state_dbg           current FSM state
// Optional feature macro: SGPIO_SDATAIN_EN (drive_present / sdin ID bits).
module sgpio_rx_multi
    import sgpio_pkg::*;
#(
    parameter int   DRIVE_NUM    = 8,
    parameter int   TIMEOUT_CYC  = 25000,
    parameter logic LED_SAFE_VAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sgpio_rx_multi_if.slave      bus,
`ifdef SGPIO_SDATAIN_EN
    input  logic [DRIVE_NUM-1:0] drive_present,
`endif
    output logic [DRIVE_NUM-1:0] drive_active,
    output logic [DRIVE_NUM-1:0] drive_locate,
    output logic [DRIVE_NUM-1:0] drive_fault,
    output logic [DRIVE_NUM-1:0] drive_rebuild,
    output logic [3:0]           vendor_bits,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 link_up,
    output sgpio_state_e         state_dbg
);

    localparam int SH_W = BITS_PER_DRIVE * DRIVE_NUM;
    localparam int CW   = $clog2(SH_W + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic sclk_rise, sclk_fall, sload_s, sdout_s;

    sgpio_edge_sync #(.W(2)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (bus.sclk),
        .data_in  ({bus.sload, bus.sdout}),
        .clk_rise (sclk_rise),
        .clk_fall (sclk_fall),
        .data_q   ({sload_s, sdout_s})
    );

    sgpio_state_e           state, state_nxt;
    logic [CW-1:0]          bit_cnt;
    logic [SH_W-1:0]        shadow;
    logic [VENDOR_BITS-1:0] shadow_l;
    logic                   sload_prev;
    logic [WD_W-1:0]        wd_cnt;

    logic timeout, frame_start, vendor_slot;
    logic take_start, take_bit, do_commit, short_err;

    assign timeout     = (wd_cnt == WD_W'(TIMEOUT_CYC));
    assign frame_start = sclk_rise && sload_s && !sload_prev;
    // Bits 1..4 of a frame carry L0..L3 on sload; a 0->1 there is vendor
    // data, not a new frame start.
    assign vendor_slot = (int'(bit_cnt) >= 1) && (int'(bit_cnt) <= VENDOR_BITS);
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_SYNC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_start = 1'b0;
        take_bit   = 1'b0;
        do_commit  = 1'b0;
        short_err  = 1'b0;
        if (timeout) begin
            state_nxt = ST_SYNC;
        end else begin
            case (state)
                ST_SYNC, ST_HOLD: begin
                    if (frame_start) begin
                        state_nxt  = ST_SHIFT;
                        take_start = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (frame_start && !vendor_slot) begin
                        short_err  = 1'b1;
                        take_start = 1'b1;
                    end else if (sclk_rise) begin
                        take_bit = 1'b1;
                        if (int'(bit_cnt) == SH_W - 1) state_nxt = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    do_commit = 1'b1;
                    // A start arriving in the commit cycle is not lost.
                    if (frame_start) begin
                        state_nxt  = ST_SHIFT;
                        take_start = 1'b1;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
                default: state_nxt = ST_SYNC;
            endcase
        end
    end

    logic [DRIVE_NUM-1:0] dec_act, dec_loc, dec_flt, dec_reb;
    sgpio_led_t           led_tmp;

    always_comb begin
        dec_act = '0;
        dec_loc = '0;
        dec_flt = '0;
        dec_reb = '0;
        led_tmp = '0;
        for (int n = 0; n < DRIVE_NUM; n++) begin
            led_tmp    = sgpio_decode(shadow[BITS_PER_DRIVE*n +: BITS_PER_DRIVE]);
            dec_act[n] = led_tmp.active;
            dec_loc[n] = led_tmp.locate;
            dec_flt[n] = led_tmp.fault;
            dec_reb[n] = led_tmp.rebuild;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            shadow        <= '0;
            shadow_l      <= '0;
            sload_prev    <= 1'b0;
            wd_cnt        <= '0;
            drive_active  <= {DRIVE_NUM{LED_SAFE_VAL}};
            drive_locate  <= {DRIVE_NUM{LED_SAFE_VAL}};
            drive_fault   <= {DRIVE_NUM{LED_SAFE_VAL}};
            drive_rebuild <= {DRIVE_NUM{LED_SAFE_VAL}};
            vendor_bits   <= '0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            link_up       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= short_err;
            if (sclk_rise) sload_prev <= sload_s;

            // The start edge itself carries bit 0.
            if (take_start) begin
                shadow[0] <= sdout_s;
                bit_cnt   <= CW'(1);
            end else if (take_bit) begin
                for (int i = 0; i < SH_W; i++)
                    if (int'(bit_cnt) == i) shadow[i] <= sdout_s;
                for (int i = 0; i < VENDOR_BITS; i++)
                    if (int'(bit_cnt) == i + 1) shadow_l[i] <= sload_s;
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (timeout) begin
                drive_active  <= {DRIVE_NUM{LED_SAFE_VAL}};
                drive_locate  <= {DRIVE_NUM{LED_SAFE_VAL}};
                drive_fault   <= {DRIVE_NUM{LED_SAFE_VAL}};
                drive_rebuild <= {DRIVE_NUM{LED_SAFE_VAL}};
                vendor_bits   <= '0;
                link_up       <= 1'b0;
            end else if (do_commit) begin
                drive_active  <= dec_act;
                drive_locate  <= dec_loc;
                drive_fault   <= dec_flt;
                drive_rebuild <= dec_reb;
                vendor_bits   <= shadow_l;
                frame_done    <= 1'b1;
                link_up       <= 1'b1;
            end

            if (sclk_rise || sclk_fall || timeout) wd_cnt <= '0;
            else                                   wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

`ifdef SGPIO_SDATAIN_EN
    logic sdin_q;

    // ID bit for slot s: bit 0 of each drive's triple is ~present, others 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sdin_q <= 1'b1;
        end else if (state != ST_SHIFT) begin
            sdin_q <= 1'b1;
        end else if (sclk_fall) begin
            sdin_q <= 1'b0;
            for (int n = 0; n < DRIVE_NUM; n++)
                if (int'(bit_cnt) == BITS_PER_DRIVE * n) sdin_q <= ~drive_present[n];
        end
    end

    assign bus.sdin = sdin_q;
`endif

endmodule

// File: tb/tb_sgpio_rx_multi.sv
// Directed testbench for sgpio_rx_multi with DRIVE_NUM=4, TIMEOUT_CYC=25000.
module tb_sgpio_rx_multi;
    import sgpio_pkg::*;

    localparam int N = 4;

    // Frame A: drive3..drive0 = 110,100,010,001
    localparam logic [11:0] FR_A  = 12'b110_100_010_001;
    localparam logic [3:0]  A_ACT = 4'b0001, A_LOC = 4'b0010, A_FLT = 4'b0100, A_REB = 4'b1000;
    // Frame B: drive3..drive0 = 101,011,000,111
    localparam logic [11:0] FR_B  = 12'b101_011_000_111;
    localparam logic [3:0]  B_ACT = 4'b1101, B_LOC = 4'b0100, B_FLT = 4'b1000, B_REB = 4'b0001;

    logic clk = 1'b0;
    logic rst, sclk, sload, sdout;
    logic [N-1:0] drive_active, drive_locate, drive_fault, drive_rebuild;
    logic [3:0] vendor_bits;
    logic frame_done, frame_err, link_up;
    sgpio_state_e state_dbg;

    int tests = 0;
    int failed = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sgpio_rx_multi_if bus_if ();
    assign bus_if.sclk  = sclk;
    assign bus_if.sload = sload;
    assign bus_if.sdout = sdout;

    sgpio_rx_multi #(.DRIVE_NUM(N), .TIMEOUT_CYC(25000), .LED_SAFE_VAL(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if.slave),
`ifdef SGPIO_SDATAIN_EN
        .drive_present (4'b1010),
`endif
        .drive_active  (drive_active),
        .drive_locate  (drive_locate),
        .drive_fault   (drive_fault),
        .drive_rebuild (drive_rebuild),
        .vendor_bits   (vendor_bits),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .link_up       (link_up),
        .state_dbg     (state_dbg)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
        end
    end

    // One SGPIO bit: data set while sclk low, then sclk rises.
    task automatic put_bit(input logic d, input logic l);
        @(negedge clk);
        sclk = 1'b0; sdout = d; sload = l;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [11:0] bits, input logic [3:0] lb, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            logic d, l;
            d = (i < 12) ? bits[i] : 1'b1;
            if (i == 0)      l = 1'b1;
            else if (i <= 4) l = lb[i-1];
            else             l = 1'b0;
            put_bit(d, l);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; sload = 1'b0; sdout = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (drive_active !== 4'hF) begin failed++; $display("FAIL reset_active: got %b want 1111", drive_active); end
        tests++; if (drive_fault !== 4'hF) begin failed++; $display("FAIL reset_fault: got %b want 1111", drive_fault); end
        tests++; if (vendor_bits !== 4'h0) begin failed++; $display("FAIL reset_vendor: got %b want 0000", vendor_bits); end
        tests++; if (link_up !== 1'b0) begin failed++; $display("FAIL reset_link: got %b want 0", link_up); end
        tests++; if ({frame_done, frame_err} !== 2'b00) begin failed++; $display("FAIL reset_pulses: got %b want 00", {frame_done, frame_err}); end
        tests++; if (state_dbg !== ST_SYNC) begin failed++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_SYNC); end
    endtask

    task automatic test_decode();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 11; i++) put_bit(FR_A[i], (i == 0) ? 1'b1 : 1'b0);
        @(negedge clk);
        sclk = 1'b0; sdout = FR_A[11]; sload = 1'b0;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (drive_active !== 4'hF) begin failed++; $display("FAIL latency_early: got %b want 1111", drive_active); end
        @(posedge clk);
        #1;
        tests++; if (drive_active !== A_ACT) begin failed++; $display("FAIL latency_commit: got %b want %b", drive_active, A_ACT); end
        tests++; if (frame_done !== 1'b1) begin failed++; $display("FAIL done_pulse: got %b want 1", frame_done); end
        repeat (4) @(negedge clk);
        tests++; if (drive_locate !== A_LOC) begin failed++; $display("FAIL a_locate: got %b want %b", drive_locate, A_LOC); end
        tests++; if (drive_fault !== A_FLT) begin failed++; $display("FAIL a_fault: got %b want %b", drive_fault, A_FLT); end
        tests++; if (drive_rebuild !== A_REB) begin failed++; $display("FAIL a_rebuild: got %b want %b", drive_rebuild, A_REB); end
        tests++; if (link_up !== 1'b1) begin failed++; $display("FAIL a_link: got %b want 1", link_up); end
        tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL a_done_count: got %0d want 1", done_cnt - d0); end
        tests++; if (state_dbg !== ST_HOLD) begin failed++; $display("FAIL a_state: got %0d want %0d", state_dbg, ST_HOLD); end
    endtask

    task automatic test_vendor();
        send_frame(FR_B, 4'b1101, 12);
        repeat (2) @(negedge clk);
        tests++; if (vendor_bits !== 4'b1101) begin failed++; $display("FAIL vendor: got %b want 1101", vendor_bits); end
        tests++; if (drive_active !== B_ACT) begin failed++; $display("FAIL b_active: got %b want %b", drive_active, B_ACT); end
        tests++; if (drive_locate !== B_LOC) begin failed++; $display("FAIL b_locate: got %b want %b", drive_locate, B_LOC); end
        tests++; if (drive_fault !== B_FLT) begin failed++; $display("FAIL b_fault: got %b want %b", drive_fault, B_FLT); end
        tests++; if (drive_rebuild !== B_REB) begin failed++; $display("FAIL b_rebuild: got %b want %b", drive_rebuild, B_REB); end
        tests++; if (err_cnt !== 0) begin failed++; $display("FAIL vendor_no_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_short_frame();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(FR_A, 4'b0000, 7);
        tests++; if (drive_active !== B_ACT) begin failed++; $display("FAIL short_hold: got %b want %b", drive_active, B_ACT); end
        send_frame(FR_A, 4'b0000, 12);
        repeat (2) @(negedge clk);
        tests++; if (err_cnt - e0 !== 1) begin failed++; $display("FAIL short_err_count: got %0d want 1", err_cnt - e0); end
        tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL short_done_count: got %0d want 1", done_cnt - d0); end
        tests++; if (drive_active !== A_ACT) begin failed++; $display("FAIL short_active: got %b want %b", drive_active, A_ACT); end
        tests++; if (drive_rebuild !== A_REB) begin failed++; $display("FAIL short_rebuild: got %b want %b", drive_rebuild, A_REB); end
        tests++; if (vendor_bits !== 4'b0000) begin failed++; $display("FAIL short_vendor: got %b want 0000", vendor_bits); end
    endtask

    task automatic test_long_frame();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(FR_B, 4'b0000, 20);
        repeat (2) @(negedge clk);
        tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL long_done_count: got %0d want 1", done_cnt - d0); end
        tests++; if (err_cnt - e0 !== 0) begin failed++; $display("FAIL long_err_count: got %0d want 0", err_cnt - e0); end
        tests++; if (drive_active !== B_ACT) begin failed++; $display("FAIL long_active: got %b want %b", drive_active, B_ACT); end
        tests++; if (drive_locate !== B_LOC) begin failed++; $display("FAIL long_locate: got %b want %b", drive_locate, B_LOC); end
        tests++; if (drive_fault !== B_FLT) begin failed++; $display("FAIL long_fault: got %b want %b", drive_fault, B_FLT); end
        tests++; if (state_dbg !== ST_HOLD) begin failed++; $display("FAIL long_state: got %0d want %0d", state_dbg, ST_HOLD); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        sclk = 1'b0;
        // Fall pulse clears the counter 2 clks later; it reaches 25000 one
        // edge before the outputs change.
        repeat (25003) @(posedge clk);
        #1;
        tests++; if (link_up !== 1'b1) begin failed++; $display("FAIL wd_early_link: got %b want 1", link_up); end
        tests++; if (drive_active !== B_ACT) begin failed++; $display("FAIL wd_early_active: got %b want %b", drive_active, B_ACT); end
        @(posedge clk);
        #1;
        tests++; if (link_up !== 1'b0) begin failed++; $display("FAIL wd_link: got %b want 0", link_up); end
        tests++; if ({drive_active, drive_locate, drive_fault, drive_rebuild} !== 16'hFFFF) begin
            failed++; $display("FAIL wd_leds: got %h want ffff", {drive_active, drive_locate, drive_fault, drive_rebuild}); end
        tests++; if (vendor_bits !== 4'b0000) begin failed++; $display("FAIL wd_vendor: got %b want 0000", vendor_bits); end
        tests++; if (state_dbg !== ST_SYNC) begin failed++; $display("FAIL wd_state: got %0d want %0d", state_dbg, ST_SYNC); end
        send_frame(FR_A, 4'b0000, 12);
        repeat (2) @(negedge clk);
        tests++; if (drive_active !== A_ACT) begin failed++; $display("FAIL wd_restore_active: got %b want %b", drive_active, A_ACT); end
        tests++; if (drive_locate !== A_LOC) begin failed++; $display("FAIL wd_restore_locate: got %b want %b", drive_locate, A_LOC); end
        tests++; if (link_up !== 1'b1) begin failed++; $display("FAIL wd_restore_link: got %b want 1", link_up); end
    endtask

    task automatic test_reset_mid();
        int d0;
        send_frame(FR_B, 4'b0000, 5);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++; if ({drive_active, drive_locate, drive_fault, drive_rebuild} !== 16'hFFFF) begin
            failed++; $display("FAIL rstmid_leds: got %h want ffff", {drive_active, drive_locate, drive_fault, drive_rebuild}); end
        tests++; if (link_up !== 1'b0) begin failed++; $display("FAIL rstmid_link: got %b want 0", link_up); end
        tests++; if (vendor_bits !== 4'b0000) begin failed++; $display("FAIL rstmid_vendor: got %b want 0000", vendor_bits); end
        tests++; if (state_dbg !== ST_SYNC) begin failed++; $display("FAIL rstmid_state: got %0d want %0d", state_dbg, ST_SYNC); end
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 12; i++) put_bit(FR_A[i], 1'b0);
        repeat (2) @(negedge clk);
        tests++; if (done_cnt - d0 !== 0) begin failed++; $display("FAIL nostart_done_count: got %0d want 0", done_cnt - d0); end
        tests++; if (drive_active !== 4'hF) begin failed++; $display("FAIL nostart_active: got %b want 1111", drive_active); end
        tests++; if (state_dbg !== ST_SYNC) begin failed++; $display("FAIL nostart_state: got %0d want %0d", state_dbg, ST_SYNC); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_vendor();
        test_short_frame();
        test_long_frame();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
